// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the iterative branch comparator: mode codes,
// FSM state encoding and the final mode-to-condition mapping.
package branch_cmp_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LEZ = 3'd2;
  localparam logic [2:0] CMP_GTZ = 3'd3;
  localparam logic [2:0] CMP_LTZ = 3'd4;
  localparam logic [2:0] CMP_GEZ = 3'd5;
  localparam logic [2:0] CMP_LTU = 3'd6;
  localparam logic [2:0] CMP_LT  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Compare-against-zero modes: op_b is replaced by 0 when latched.
  function automatic logic is_zero_mode(input logic [2:0] mode);
    return (mode >= CMP_LEZ) && (mode <= CMP_GEZ);
  endfunction

  // Modes that need two's-complement ordering.
  function automatic logic is_signed_mode(input logic [2:0] mode);
    return is_zero_mode(mode) || (mode == CMP_LT);
  endfunction

  // Map the accumulated a==b / a<b outcome onto the requested condition.
  function automatic logic cond_from(input logic [2:0] mode, input logic eq, input logic lt);
    logic c;
    case (mode)
      CMP_EQ:  c = eq;
      CMP_NE:  c = !eq;
      CMP_LEZ: c = lt || eq;
      CMP_GTZ: c = !lt && !eq;
      CMP_LTZ: c = lt;
      CMP_GEZ: c = !lt;
      CMP_LTU: c = lt;
      default: c = lt;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational CHUNK-bit unsigned compare of one operand slice. The MSB of
// both slices can be flipped so that a signed top slice orders correctly.
module cmp_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] w_msk;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  assign w_msk = CHUNK'(invert_msb) << (CHUNK - 1);
  assign w_a   = a ^ w_msk;
  assign w_b   = b ^ w_msk;
  assign eq    = (w_a == w_b);
  assign lt    = (w_a <  w_b);

endmodule

// File: rtl/iter_branch_cmp.sv
// Multi-cycle branch-condition resolver. Compares op_a with op_b (or zero)
// MSB-first, one CHUNK-bit slice per cycle, with a start/busy/done handshake.
// Optional feature macro: CMP_EARLY_EXIT_EN -- finish RUN at the first
// differing slice instead of always walking all NCHUNK slices.
module iter_branch_cmp
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_e                         r_state;
  state_e                         w_state_nxt;
  logic [2:0]                     r_mode;
  logic [WIDTH-1:0]               r_a;
  logic [WIDTH-1:0]               r_b;
  logic                           r_eq;
  logic                           r_lt;
  logic [IDXW-1:0]                r_idx;
  logic                           r_done;
  logic                           r_result;

  logic [NCHUNK-1:0][CHUNK-1:0]   w_a_sl;
  logic [NCHUNK-1:0][CHUNK-1:0]   w_b_sl;
  logic                           w_inv;
  logic                           w_seq;
  logic                           w_slt;
  logic                           w_eq_nxt;
  logic                           w_lt_nxt;
  logic                           w_last;
  logic                           w_latch;
  logic                           w_step;
  logic                           w_finish;

  // Single slice comparator, fed by the slice at r_idx.
  assign w_a_sl = r_a;
  assign w_b_sl = r_b;
  assign w_inv  = is_signed_mode(r_mode) && (r_idx == IDX_TOP);

  cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .a          (w_a_sl[r_idx]),
    .b          (w_b_sl[r_idx]),
    .invert_msb (w_inv),
    .eq         (w_seq),
    .lt         (w_slt)
  );

  // Once a higher slice has differed, lower slices cannot change the outcome.
  assign w_eq_nxt = r_eq && w_seq;
  assign w_lt_nxt = r_eq ? w_slt : r_lt;

`ifdef CMP_EARLY_EXIT_EN
  // A first differing slice settles every mode, so stop there.
  assign w_last = (r_idx == '0) || (r_eq && !w_seq);
`else
  assign w_last = (r_idx == '0);
`endif

  assign busy   = (r_state == ST_RUN);
  assign done   = r_done;
  assign result = r_result;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and datapath controls; flush wins over start and over finishing.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, slice accumulators, and registered done/result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= CMP_EQ;
      r_a      <= '0;
      r_b      <= '0;
      r_eq     <= 1'b1;
      r_lt     <= 1'b0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_result <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_latch) begin
        r_mode <= mode;
        r_a    <= op_a;
        r_b    <= is_zero_mode(mode) ? '0 : op_b;
        r_eq   <= 1'b1;
        r_lt   <= 1'b0;
        r_idx  <= IDX_TOP;
      end
      if (w_step) begin
        r_eq  <= w_eq_nxt;
        r_lt  <= w_lt_nxt;
        r_idx <= r_idx - 1'b1;
      end
      if (w_finish) r_result <= cond_from(r_mode, w_eq_nxt, w_lt_nxt);
    end
  end

endmodule

// File: tb/tb_iter_branch_cmp.sv
// Self-checking bench for iter_branch_cmp (WIDTH=32, CHUNK=8): directed
// table, randomized vectors against an arithmetic reference model, and
// hand-written flush / dropped-start / async-reset sequences.
module tb_iter_branch_cmp;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCH    = WIDTH / CHUNK;
  localparam int FULL   = NCH + 1;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             result;

  int n_vec  = 0;
  int n_miss = 0;

  iter_branch_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: condition straight from two's-complement / unsigned arithmetic.
  function automatic logic model_res(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] be;
    be = (m >= 3'd2 && m <= 3'd5) ? 32'd0 : b;
    case (m)
      3'd0: return a == be;
      3'd1: return a != be;
      3'd2: return $signed(a) <= 0;
      3'd3: return $signed(a) >  0;
      3'd4: return $signed(a) <  0;
      3'd5: return $signed(a) >= 0;
      3'd6: return a < be;
      default: return $signed(a) < $signed(be);
    endcase
  endfunction

  // Reference latency in cycles from the start cycle to the done cycle.
  function automatic int model_lat(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] be;
    be = (m >= 3'd2 && m <= 3'd5) ? 32'd0 : b;
`ifdef CMP_EARLY_EXIT_EN
    for (int k = 1; k <= NCH; k++) begin
      if (a[WIDTH-1-(k-1)*CHUNK -: CHUNK] != be[WIDTH-1-(k-1)*CHUNK -: CHUNK]) return k + 1;
    end
`endif
    return FULL;
  endfunction

  // Present a request; must be called right at a falling edge.
  task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mode = m; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done, checking busy every cycle. inj>0 pulses a junk start in that cycle.
  task automatic await(input string name, input logic exp_res, input int exp_lat, input int inj);
    int got;
    logic busy_ok;
    got = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy !== (n < exp_lat)) busy_ok = 1'b0;
      if (n == inj + 1 && inj > 0) start = 1'b0;
      if (done === 1'b1) begin got = n; break; end
      if (n == inj) begin
        start = 1'b1; mode = 3'd1; op_a = 32'h1; op_b = 32'h2;
      end
    end
    chk({name, " latency"}, got, exp_lat);
    chk({name, " result"}, {31'd0, result}, {31'd0, exp_res});
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic        res;
    int          lat_early;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lat;
    logic [2:0]  m;
    logic [31:0] a, b;
    int donecnt;

    tbl[0]  = '{"eq_same",    3'd0, 32'h12345678, 32'h12345678, 1'b1, 5};
    tbl[1]  = '{"lt_neg",     3'd7, 32'hFFFFFFFF, 32'h00000001, 1'b1, 2};
    tbl[2]  = '{"ltu_big",    3'd6, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2};
    tbl[3]  = '{"ne_msb",     3'd1, 32'h80000000, 32'h00000000, 1'b1, 2};
    tbl[4]  = '{"gez_zero",   3'd5, 32'h00000000, 32'hFFFFFFFF, 1'b1, 5};
    tbl[5]  = '{"ltz_min",    3'd4, 32'h80000000, 32'h00000000, 1'b1, 2};
    tbl[6]  = '{"gtz_zero",   3'd3, 32'h00000000, 32'h00000000, 1'b0, 5};
    tbl[7]  = '{"lez_one",    3'd2, 32'h00000001, 32'h12345678, 1'b0, 5};
    tbl[8]  = '{"lez_m1",     3'd2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2};
    tbl[9]  = '{"eq_lsb",     3'd0, 32'h12345678, 32'h12345679, 1'b0, 5};
    tbl[10] = '{"eq_slice2",  3'd0, 32'h12005678, 32'h12345678, 1'b0, 3};
    tbl[11] = '{"lt_posneg",  3'd7, 32'h7FFFFFFF, 32'h80000000, 1'b0, 2};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; mode = 3'd0; op_a = '0; op_b = '0;
    #12;
    chk("reset busy",   {31'd0, busy},   32'd0);
    chk("reset done",   {31'd0, done},   32'd0);
    chk("reset result", {31'd0, result}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back from each done cycle.
    foreach (tbl[i]) begin
`ifdef CMP_EARLY_EXIT_EN
      lat = tbl[i].lat_early;
`else
      lat = FULL;
`endif
      issue(tbl[i].m, tbl[i].a, tbl[i].b);
      await(tbl[i].name, tbl[i].res, lat, 0);
    end

    // Randomized vectors against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      m = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 2)) - 32'd1;
      issue(m, a, b);
      await("rand", model_res(m, a, b), model_lat(m, a, b), 0);
    end

    // Start during busy is dropped: result follows the first request, no second done.
    issue(3'd0, 32'h5, 32'h5);
    await("drop_start", 1'b1, FULL, 2);
    donecnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done === 1'b1) donecnt++;
    end
    chk("drop_start no extra done", donecnt, 0);

    // Flush in RUN cycle 2: IDLE next cycle, no done, result keeps prior 1.
    issue(3'd1, 32'h1, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy",   {31'd0, busy},   32'd0);
    chk("flush result", {31'd0, result}, 32'd1);
    donecnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (done === 1'b1) donecnt++;
      @(negedge clk);
    end
    chk("flush no done", donecnt, 0);

    // Asynchronous reset mid-RUN, then a normal compare.
    issue(3'd0, 32'h7, 32'h7);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst busy",   {31'd0, busy},   32'd0);
    chk("async rst done",   {31'd0, done},   32'd0);
    chk("async rst result", {31'd0, result}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(3'd7, 32'hFFFFFF00, 32'h00000010);
    await("after_reset", 1'b1, model_lat(3'd7, 32'hFFFFFF00, 32'h00000010), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
